poly_sine_mixer: RTL

- Downstream consumer of the 8-voice phase accumulator.
- On each audio sample strobe it snapshots all 8 phase words and gates, and time-multiplexes them through one internal quarter-wave sine ROM.
- It sums the gated voices and emits one signed 16-bit mixed sample per strobe to the audio output path (PDM/PWM stage).

---
 rtl/poly_sine_mixer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/poly_sine_mixer.sv
// ============================================================================
// Module      : poly_sine_mixer
// Description : Snapshots 8 voice phases/gates per sample tick, looks each up
//               in a shared quarter-wave sine ROM and emits the scaled sum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module poly_sine_mixer #(
    parameter int NUM_VOICES = 8,
    parameter int GAIN_SHIFT = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     sample_tick_in,
    input  logic [NUM_VOICES-1:0]    gate_in,
    input  logic [31:0]              phase_value_in [NUM_VOICES-1:0],
    output logic signed [15:0]       sample_out,
    output logic                     sample_valid_out,
    output logic                     busy_out,
    output logic                     overrun_out
);

    localparam int c_voice_w = $clog2(NUM_VOICES);
    localparam logic [c_voice_w-1:0] c_last_voice = c_voice_w'(NUM_VOICES - 1);
    localparam logic [c_voice_w-1:0] c_drain_last = c_voice_w'(2);

    // Quarter-wave entry q[k] = round(32767*sin(pi*(2k+1)/1024)) from a Q30
    // Taylor series; evaluated only at elaboration time.
    function automatic logic [15:0] sine_q(input int k);
        longint x;
        longint x2;
        longint term;
        longint sum;
        x    = (64'sd3373259426 * longint'(2 * k + 1)) / 64'sd1024;
        x2   = ((x * x) + (64'sd1 <<< 29)) >>> 30;
        term = x;
        sum  = x;
        for (int n = 1; n <= 10; n++) begin
            term = -(((term * x2) + (64'sd1 <<< 29)) >>> 30) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return 16'((sum * 64'sd32767 + (64'sd1 <<< 29)) >>> 30);
    endfunction

    logic [15:0] w_rom [0:255];

    for (genvar gk = 0; gk < 256; gk++) begin : g_rom
        localparam logic [15:0] c_q = sine_q(gk);
        assign w_rom[gk] = c_q;
    end

    // Only the top 10 phase bits address the table.
    logic [NUM_VOICES*10-1:0] w_idx_all;
    logic [NUM_VOICES*22-1:0] w_unused_phase_lo;

    for (genvar gv = 0; gv < NUM_VOICES; gv++) begin : g_snap
        assign w_idx_all[gv*10 +: 10]         = phase_value_in[gv][31:22];
        assign w_unused_phase_lo[gv*22 +: 22] = phase_value_in[gv][21:0];
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                   r_state;
    logic [c_voice_w-1:0]     r_cnt;
    logic [NUM_VOICES*10-1:0] r_idx_all;
    logic [NUM_VOICES-1:0]    r_gate;

    logic                     r_a_valid;
    logic [7:0]               r_a_addr;
    logic                     r_a_neg;
    logic                     r_a_gate;
    logic                     r_b_valid;
    logic [15:0]              r_b_data;
    logic                     r_b_neg;
    logic                     r_b_gate;
    logic                     r_c_valid;
    logic signed [15:0]       r_c_val;
    logic signed [19:0]       r_acc;

    logic [9:0]               w_cur_idx;
    logic signed [15:0]       w_b_signed;
    logic signed [19:0]       w_shifted;
    logic signed [15:0]       w_sat;

    always_comb begin
        w_cur_idx = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (r_cnt == c_voice_w'(v)) begin
                w_cur_idx = r_idx_all[v*10 +: 10];
            end
        end
    end

    assign w_b_signed = signed'(r_b_data);
    assign w_shifted  = r_acc >>> GAIN_SHIFT;

    always_comb begin
        w_sat = w_shifted[15:0];
        if (w_shifted > 20'sd32767) begin
            w_sat = 16'sh7FFF;
        end else if (w_shifted < -20'sd32768) begin
            w_sat = 16'sh8000;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state          <= S_IDLE;
            r_cnt            <= '0;
            r_idx_all        <= '0;
            r_gate           <= '0;
            r_a_valid        <= 1'b0;
            r_a_addr         <= '0;
            r_a_neg          <= 1'b0;
            r_a_gate         <= 1'b0;
            r_b_valid        <= 1'b0;
            r_b_data         <= '0;
            r_b_neg          <= 1'b0;
            r_b_gate         <= 1'b0;
            r_c_valid        <= 1'b0;
            r_c_val          <= '0;
            r_acc            <= '0;
            sample_out       <= '0;
            sample_valid_out <= 1'b0;
            busy_out         <= 1'b0;
            overrun_out      <= 1'b0;
        end else begin
            r_a_valid        <= 1'b0;
            r_b_valid        <= r_a_valid;
            r_b_data         <= w_rom[r_a_addr];
            r_b_neg          <= r_a_neg;
            r_b_gate         <= r_a_gate;
            r_c_valid        <= r_b_valid;
            r_c_val          <= !r_b_gate ? 16'sd0 : (r_b_neg ? -w_b_signed : w_b_signed);
            sample_valid_out <= 1'b0;

            if (r_c_valid) begin
                r_acc <= r_acc + {{4{r_c_val[15]}}, r_c_val};
            end

            if (sample_tick_in && (r_state != S_IDLE)) begin
                overrun_out <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (sample_tick_in) begin
                        r_idx_all <= w_idx_all;
                        r_gate    <= gate_in;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        busy_out  <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Odd quadrants walk the quarter table backwards.
                    r_a_valid <= 1'b1;
                    r_a_addr  <= w_cur_idx[8] ? ~w_cur_idx[7:0] : w_cur_idx[7:0];
                    r_a_neg   <= w_cur_idx[9];
                    r_a_gate  <= r_gate[r_cnt];
                    r_cnt     <= r_cnt + 1'b1;
                    if (r_cnt == c_last_voice) begin
                        r_cnt   <= '0;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_drain_last) begin
                        r_state <= S_OUT;
                    end
                end
                S_OUT: begin
                    sample_out       <= w_sat;
                    sample_valid_out <= 1'b1;
                    busy_out         <= 1'b0;
                    r_state          <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
